// File: rtl/micro_sequencer_if.sv
// Control-store side bundle of the MICRO-1 microprogram sequencer: microword
// sequencing fields and datapath status in, microaddress and stack status out.
interface micro_sequencer_if #(
    parameter int UADDR_W     = 10,
    parameter int STACK_DEPTH = 4,
    parameter int COND_N      = 8,
    parameter int OPCODE_W    = 8
);
    localparam int CSEL_W  = (COND_N > 1) ? $clog2(COND_N) : 1;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [2:0]          seq_op;
    logic [UADDR_W-1:0]  seq_target;
    logic [CSEL_W-1:0]   cond_sel;
    logic [COND_N-1:0]   cond_in;
    logic [OPCODE_W-1:0] opcode;
    logic [UADDR_W-1:0]  dispatch_base;
    logic                inbus_valid;
    logic                stall;

    logic [UADDR_W-1:0]  upc;
    logic                waiting;
    logic [DEPTH_W-1:0]  depth;
    logic                stack_overflow;
    logic                stack_underflow;

    modport master (
        output seq_op, seq_target, cond_sel, cond_in, opcode, dispatch_base,
               inbus_valid, stall,
        input  upc, waiting, depth, stack_overflow, stack_underflow
    );

    modport slave (
        input  seq_op, seq_target, cond_sel, cond_in, opcode, dispatch_base,
               inbus_valid, stall,
        output upc, waiting, depth, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/micro_sequencer.sv
// MICRO-1 microprogram sequencer: owns the uPC, resolves conditional branches,
// opcode dispatch, input-bus waits and a micro-subroutine return stack.
module micro_sequencer #(
    parameter int                    UADDR_W     = 10,
    parameter int                    STACK_DEPTH = 4,
    parameter int                    COND_N      = 8,
    parameter int                    OPCODE_W    = 8,
    parameter logic [UADDR_W-1:0]    RESET_ADDR  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    micro_sequencer_if.slave     bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NEXT     = 3'd0,
        OP_JUMP     = 3'd1,
        OP_CJUMP    = 3'd2,
        OP_CNJUMP   = 3'd3,
        OP_CALL     = 3'd4,
        OP_RET      = 3'd5,
        OP_DISPATCH = 3'd6,
        OP_WAIT     = 3'd7
    } seq_op_e;

    seq_op_e             op;
    logic [UADDR_W-1:0]  upc_q, upc_d, upc_inc, dispatch_addr, ret_addr;
    logic [DEPTH_W-1:0]  depth_q, depth_d, depth_m1;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                push_en;
    logic                cond_bit, stack_full, stack_empty;
    logic [PTR_W-1:0]    push_idx, pop_idx;
    logic [UADDR_W-1:0]  stack_mem [STACK_DEPTH];

    assign op            = seq_op_e'(bus.seq_op);
    assign upc_inc       = upc_q + 1'b1;
    assign dispatch_addr = bus.dispatch_base + UADDR_W'(bus.opcode);

    // Selector values past the last implemented condition bit read as false.
    assign cond_bit = (32'(bus.cond_sel) < 32'(COND_N)) ? bus.cond_in[bus.cond_sel] : 1'b0;

    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign depth_m1    = depth_q - 1'b1;
    assign push_idx    = depth_q[PTR_W-1:0];
    assign pop_idx     = depth_m1[PTR_W-1:0];
    assign ret_addr    = stack_mem[pop_idx];

    always_comb begin
        upc_d   = upc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!bus.stall) begin
            case (op)
                OP_NEXT:     upc_d = upc_inc;
                OP_JUMP:     upc_d = bus.seq_target;
                OP_CJUMP:    upc_d = cond_bit ? bus.seq_target : upc_inc;
                OP_CNJUMP:   upc_d = cond_bit ? upc_inc : bus.seq_target;
                OP_CALL: begin
                    // A call on a full stack still branches; only the return is lost.
                    upc_d = bus.seq_target;
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        depth_d = depth_q + 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        upc_d = upc_inc;
                        unf_d = 1'b1;
                    end else begin
                        upc_d   = ret_addr;
                        depth_d = depth_m1;
                    end
                end
                OP_DISPATCH: upc_d = dispatch_addr;
                OP_WAIT:     upc_d = bus.inbus_valid ? upc_inc : upc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q   <= RESET_ADDR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            upc_q   <= upc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-stack storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack_mem[push_idx] <= upc_inc;
        end
    end

    assign bus.upc             = upc_q;
    assign bus.depth           = depth_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
    assign bus.waiting         = (op == OP_WAIT) && !bus.inbus_valid && !bus.stall;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: expected uPC/stack state is queued when
// each microword is driven and compared after the following clock edge.
module tb_micro_sequencer;
    localparam int UADDR_W = 10;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, CJUMP = 3'd2, CNJUMP = 3'd3,
                           CALL = 3'd4, RET = 3'd5, DISPATCH = 3'd6, WAITOP = 3'd7;

    typedef struct {
        string        tag;
        logic [9:0]   upc;
        logic [2:0]   depth;
        logic         ovf;
        logic         unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    micro_sequencer_if #(.UADDR_W(10), .STACK_DEPTH(4), .COND_N(8), .OPCODE_W(8)) bus ();

    micro_sequencer #(
        .UADDR_W(10), .STACK_DEPTH(4), .COND_N(8), .OPCODE_W(8), .RESET_ADDR(10'h000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic [2:0] op, input logic [9:0] tgt,
                        input logic exp_wait, input logic [9:0] e_upc,
                        input logic [2:0] e_depth, input logic e_ovf, input logic e_unf);
        exp_t e;
        exp_t got;
        bus.seq_op     = op;
        bus.seq_target = tgt;
        #1;
        checks++;
        assert (bus.waiting === exp_wait)
        else begin
            failures++;
            $error("FAIL %s.waiting: observed %b expected %b", tag, bus.waiting, exp_wait);
        end
        e.tag = tag; e.upc = e_upc; e.depth = e_depth; e.ovf = e_ovf; e.unf = e_unf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        assert (bus.upc === got.upc)
        else begin
            failures++;
            $error("FAIL %s.upc: observed %h expected %h", got.tag, bus.upc, got.upc);
        end
        checks++;
        assert (bus.depth === got.depth)
        else begin
            failures++;
            $error("FAIL %s.depth: observed %0d expected %0d", got.tag, bus.depth, got.depth);
        end
        checks++;
        assert ({bus.stack_overflow, bus.stack_underflow} === {got.ovf, got.unf})
        else begin
            failures++;
            $error("FAIL %s.flags: observed ovf=%b unf=%b expected ovf=%b unf=%b",
                   got.tag, bus.stack_overflow, bus.stack_underflow, got.ovf, got.unf);
        end
    endtask

    initial begin
        bus.seq_op = NEXT; bus.seq_target = '0; bus.cond_sel = '0; bus.cond_in = '0;
        bus.opcode = '0; bus.dispatch_base = '0; bus.inbus_valid = 1'b0; bus.stall = 1'b0;

        rst = 1'b1;
        step("reset", NEXT, 10'h000, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        step("next1", NEXT, 10'h000, 1'b0, 10'h001, 3'd0, 1'b0, 1'b0);
        step("next2", NEXT, 10'h000, 1'b0, 10'h002, 3'd0, 1'b0, 1'b0);
        step("next3", NEXT, 10'h000, 1'b0, 10'h003, 3'd0, 1'b0, 1'b0);
        step("jump_top", JUMP, 10'h3FF, 1'b0, 10'h3FF, 3'd0, 1'b0, 1'b0);
        step("next_wrap", NEXT, 10'h000, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0);

        step("jump_050", JUMP, 10'h050, 1'b0, 10'h050, 3'd0, 1'b0, 1'b0);
        bus.cond_sel = 3'd2; bus.cond_in = 8'b0000_0100;
        step("cjump_taken", CJUMP, 10'h120, 1'b0, 10'h120, 3'd0, 1'b0, 1'b0);
        bus.cond_in = 8'b0000_0000;
        step("cjump_fall", CJUMP, 10'h300, 1'b0, 10'h121, 3'd0, 1'b0, 1'b0);
        step("cnjump_taken", CNJUMP, 10'h200, 1'b0, 10'h200, 3'd0, 1'b0, 1'b0);
        bus.cond_in = 8'b0000_0100;
        step("cnjump_fall", CNJUMP, 10'h300, 1'b0, 10'h201, 3'd0, 1'b0, 1'b0);
        bus.cond_sel = 3'd7; bus.cond_in = 8'b1000_0000;
        step("cjump_msb", CJUMP, 10'h0AA, 1'b0, 10'h0AA, 3'd0, 1'b0, 1'b0);
        bus.cond_sel = 3'd0; bus.cond_in = 8'b1111_1110;
        step("cjump_bit0_clr", CJUMP, 10'h155, 1'b0, 10'h0AB, 3'd0, 1'b0, 1'b0);

        step("jump_010", JUMP, 10'h010, 1'b0, 10'h010, 3'd0, 1'b0, 1'b0);
        step("call_100", CALL, 10'h100, 1'b0, 10'h100, 3'd1, 1'b0, 1'b0);
        step("call_200", CALL, 10'h200, 1'b0, 10'h200, 3'd2, 1'b0, 1'b0);
        step("ret_101", RET, 10'h000, 1'b0, 10'h101, 3'd1, 1'b0, 1'b0);
        step("ret_011", RET, 10'h000, 1'b0, 10'h011, 3'd0, 1'b0, 1'b0);

        step("ovf_call1", CALL, 10'h020, 1'b0, 10'h020, 3'd1, 1'b0, 1'b0);
        step("ovf_call2", CALL, 10'h030, 1'b0, 10'h030, 3'd2, 1'b0, 1'b0);
        step("ovf_call3", CALL, 10'h040, 1'b0, 10'h040, 3'd3, 1'b0, 1'b0);
        step("ovf_call4", CALL, 10'h050, 1'b0, 10'h050, 3'd4, 1'b0, 1'b0);
        step("ovf_call5", CALL, 10'h060, 1'b0, 10'h060, 3'd4, 1'b1, 1'b0);
        step("unf_ret1", RET, 10'h000, 1'b0, 10'h041, 3'd3, 1'b1, 1'b0);
        step("unf_ret2", RET, 10'h000, 1'b0, 10'h031, 3'd2, 1'b1, 1'b0);
        step("unf_ret3", RET, 10'h000, 1'b0, 10'h021, 3'd1, 1'b1, 1'b0);
        step("unf_ret4", RET, 10'h000, 1'b0, 10'h012, 3'd0, 1'b1, 1'b0);
        step("unf_ret5", RET, 10'h000, 1'b0, 10'h013, 3'd0, 1'b1, 1'b1);

        bus.stall = 1'b1;
        step("stall_call", CALL, 10'h155, 1'b0, 10'h013, 3'd0, 1'b1, 1'b1);
        bus.stall = 1'b0;

        bus.dispatch_base = 10'h3F0; bus.opcode = 8'h25;
        step("dispatch_wrap", DISPATCH, 10'h000, 1'b0, 10'h015, 3'd0, 1'b1, 1'b1);

        bus.inbus_valid = 1'b0;
        step("wait1", WAITOP, 10'h000, 1'b1, 10'h015, 3'd0, 1'b1, 1'b1);
        step("wait2", WAITOP, 10'h000, 1'b1, 10'h015, 3'd0, 1'b1, 1'b1);
        step("wait3", WAITOP, 10'h000, 1'b1, 10'h015, 3'd0, 1'b1, 1'b1);
        bus.inbus_valid = 1'b1; bus.stall = 1'b1;
        step("wait_stalled", WAITOP, 10'h000, 1'b0, 10'h015, 3'd0, 1'b1, 1'b1);
        bus.stall = 1'b0;
        step("wait_release", WAITOP, 10'h000, 1'b0, 10'h016, 3'd0, 1'b1, 1'b1);
        bus.inbus_valid = 1'b0;

        step("call_030", CALL, 10'h030, 1'b0, 10'h030, 3'd1, 1'b1, 1'b1);
        step("wait_pre_rst", WAITOP, 10'h000, 1'b1, 10'h030, 3'd1, 1'b1, 1'b1);
        rst = 1'b1;
        step("rst_in_wait", WAITOP, 10'h000, 1'b1, 10'h000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step("ret_after_rst", RET, 10'h000, 1'b0, 10'h001, 3'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
